// File: rtl/mod_counter_updown.sv
// Up/down modulo counter with clear/load, one-shot halt, wrap pulse and done status.
// Optional prescaler on the count advance, enabled with `define PRESCALER_EN.
package mod_counter_updown_pkg;
  function automatic int f_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction
endpackage

module mod_counter_updown #(
  parameter int MAX_VALUE  = 24,
  parameter int INIT_VALUE = 1,
`ifdef PRESCALER_EN
  parameter int PRESCALE   = 4,
`endif
  parameter int NBITS      = mod_counter_updown_pkg::f_clog2(MAX_VALUE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [NBITS-1:0] load_value,
  input  logic             up_down,
  input  logic             one_shot,
  output logic [NBITS-1:0] counter,
  output logic             flag,
  output logic             wrap,
`ifdef PRESCALER_EN
  output logic             tick,
`endif
  output logic             done
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  localparam logic [NBITS-1:0] LV_MAX  = NBITS'(MAX_VALUE - 1);
  localparam logic [NBITS-1:0] LV_INIT = NBITS'(INIT_VALUE);
  localparam logic [NBITS-1:0] LV_ONE  = NBITS'(1);

  state_t           r_state;
  logic [NBITS-1:0] r_counter;
  logic             r_wrap;
  logic             r_done;

  logic [NBITS-1:0] w_load_clamped;
  logic [NBITS-1:0] w_next;
  logic [NBITS-1:0] w_reload;
  logic             w_terminal;
  logic             w_run_en;
  logic             w_step;

  // Terminal values are detected before stepping, so +1/-1 never leave the range.
  assign w_load_clamped = (load_value > LV_MAX) ? LV_MAX : load_value;
  assign w_terminal     = up_down ? (r_counter == LV_MAX) : (r_counter == '0);
  assign w_next         = up_down ? (r_counter + LV_ONE) : (r_counter - LV_ONE);
  assign w_reload       = up_down ? '0 : LV_MAX;
  assign w_run_en       = enable && (r_state == S_RUN);

`ifdef PRESCALER_EN
  localparam int PBITS = (mod_counter_updown_pkg::f_clog2(PRESCALE) < 1) ? 1 :
                         mod_counter_updown_pkg::f_clog2(PRESCALE);
  localparam logic [PBITS-1:0] PV_MAX = PBITS'(PRESCALE - 1);
  localparam logic [PBITS-1:0] PV_ONE = PBITS'(1);

  logic [PBITS-1:0] r_pre;
  logic             w_pre_hit;

  assign w_pre_hit = (r_pre == PV_MAX);
  assign w_step    = w_run_en && w_pre_hit;
  assign tick      = w_step;

  // Wraps to 0 on every main-counter step, which also covers entry to HALT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
    end else if (clear || load) begin
      r_pre <= '0;
    end else if (w_run_en) begin
      r_pre <= w_pre_hit ? '0 : (r_pre + PV_ONE);
    end
  end
`else
  assign w_step = w_run_en;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_RUN;
      r_counter <= LV_INIT;
      r_wrap    <= 1'b0;
      r_done    <= 1'b0;
    end else if (clear) begin
      r_state   <= S_RUN;
      r_counter <= '0;
      r_wrap    <= 1'b0;
      r_done    <= 1'b0;
    end else if (load) begin
      r_state   <= S_RUN;
      r_counter <= w_load_clamped;
      r_wrap    <= 1'b0;
      r_done    <= 1'b0;
    end else if (w_step) begin
      if (w_terminal) begin
        r_wrap <= 1'b1;
        if (one_shot) begin
          r_state <= S_HALT;
          r_done  <= 1'b1;
        end else begin
          r_counter <= w_reload;
        end
      end else begin
        r_counter <= w_next;
        r_wrap    <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign counter = r_counter;
  assign flag    = (r_counter == '0);
  assign wrap    = r_wrap;
  assign done    = r_done;

endmodule

// File: doc/mod_counter_updown.md
Name: mod_counter_updown

Overview:
Parametrised up/down modulo counter, successor to the fixed-direction modulo counter used by timing and sequencing logic. Adds direction control, synchronous clear and load, one-shot/auto-reload mode, a registered wrap pulse and a done status. Sits beside control FSMs as the general-purpose event counter and divider.

Parameters:
MAX_VALUE, 24, modulus; count range is 0 .. MAX_VALUE-1; must be >= 2.
NBITS, ceil(log2(MAX_VALUE)), counter width, computed by a constant ceil-log2 function.
INIT_VALUE, 1, counter value on reset; must be < MAX_VALUE.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
enable  input  1  count advance qualifier.
clear  input  1  synchronous clear to 0.
load  input  1  synchronous load of load_value.
load_value  input  NBITS  value to load.
up_down  input  1  1 = count up, 0 = count down.
one_shot  input  1  1 = stop at terminal count, 0 = auto-reload.
counter  output  NBITS  registered count.
flag  output  1  high while counter == 0; decoded from the counter register.
wrap  output  1  registered one-cycle pulse on a terminal-count event.
done  output  1  registered; high while halted in one-shot mode.

Behaviour:
- Reset (reset = 0, asynchronous): counter = INIT_VALUE, wrap = 0, done = 0, state = RUN.
- Two states:
  - RUN: counts on enabled cycles.
  - HALT: counter frozen; done = 1.
- Per-cycle priority, evaluated in both states:
  - clear: counter <= 0, state <= RUN, done <= 0, wrap <= 0.
  - else load: counter <= min(load_value, MAX_VALUE-1), state <= RUN, done <= 0, wrap <= 0.
  - else enable in RUN: count step as below.
  - else: hold; wrap <= 0.
- Up step: if counter == MAX_VALUE-1, the event is terminal; otherwise counter + 1.
- Down step: if counter == 0, the event is terminal; otherwise counter - 1.
- Terminal event, auto-reload (one_shot = 0):
  - counter <= 0 (up) or MAX_VALUE-1 (down).
  - wrap <= 1 for exactly that cycle, so wrap is high on the first cycle the new value is visible.
- Terminal event, one_shot = 1:
  - counter holds the terminal value.
  - wrap <= 1 for one cycle.
  - state <= HALT and done <= 1 on the same edge.
- HALT: enable ignored; exited only by clear, load or reset.
- up_down and one_shot are sampled every cycle; a direction change takes effect on the next enabled step with no extra latency.
- Arithmetic:
  - No value outside 0 .. MAX_VALUE-1 is ever produced.
  - Increment and decrement are NBITS wide with no overflow path.
  - Loaded out-of-range values are clamped to MAX_VALUE-1.
- Reset asserted mid-count or in HALT returns everything to reset values immediately.

Optional Feature:
Macro PRESCALER_EN.
- Defined:
  - Adds parameter PRESCALE, default 4, and an internal ceil(log2(PRESCALE))-bit prescale counter.
  - The prescale counter advances on enabled RUN cycles.
  - The main counter steps only when the prescale counter reaches PRESCALE-1, then the prescale counter returns to 0.
  - Adds output tick, 1 bit, combinationally high when enable is high, state is RUN and the prescale counter equals PRESCALE-1.
  - Prescale counter resets to 0 on reset, clear, load and on entry to HALT.
- Not defined: no PRESCALE parameter, no tick port; every enabled RUN cycle steps the main counter.

Test Plan:
1. Reset check (defaults, one_shot = 0): release reset, hold enable = 0 -> counter = 1, flag = 0, wrap = 0, done = 0.
2. Up count and wrap (defaults, one_shot = 0): reset, enable = 1, up_down = 1 for 23 cycles -> counter sequence 2 .. 23, then 0 with wrap = 1 for one cycle and flag = 1; next cycle counter = 1, wrap = 0.
3. Down count and wrap (one_shot = 0): load 2, then up_down = 0, enable = 1 -> counter 1, 0, then 23 with wrap pulse, then 22.
4. One-shot and HALT: clear, one_shot = 1, up_down = 1, enable = 1 for 30 cycles -> counter stops at 23; wrap pulses once; done = 1 from that edge; counter stays 23 with no further wrap. Then load 5 -> counter = 5, done = 0, counting resumes.
5. Priority and clamp: clear = 1, load = 1, enable = 1 in the same cycle -> counter = 0. Then load_value = 31 with load = 1 -> counter = 23.
6. Prescaler (PRESCALER_EN defined, PRESCALE = 4): enable = 1, up -> counter steps once every 4 cycles, with tick high on the enabled cycle before each step. An async reset pulse mid-count returns counter = 1 and the prescale counter to 0.
